ps2_key_ctrl: RTL and testbench
===============================

# ps2_key_ctrl

Scancode-sequencing controller between the PS/2 byte receiver and the game logic. Consumes one received byte per `rx_valid` pulse and tracks the set-2 prefix sequence (`E0` extended, `F0` break). It maintains a live pressed/released bitmap for the ten player keys and queues key-change events in a small FIFO for the game FSM. Unmapped codes and typematic repeats are filtered out so downstream logic sees only real key transitions.

## Interface
- `FIFO_DEPTH`, 4: event FIFO depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 1250000: prefix-abandon timeout (25 ms at 50 MHz). Used only with `KEY_CTRL_TIMEOUT_EN`.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` holds a complete received byte.
- `rx_data` in 8: received scancode byte.
- `key_state` out 10: pressed bitmap, 1 = held. Bit order: 0 W, 1 A, 2 S, 3 D, 4 Space, 5 Up, 6 Left, 7 Down, 8 Right, 9 Enter.
- `ev_valid` out 1: FIFO non-empty.
- `ev_data` out 5: head event `{make, key_idx[3:0]}`; make = 1 press, 0 release.
- `ev_rd` in 1: pop the head event; ignored when `ev_valid` = 0.
- `ev_count` out `$clog2(FIFO_DEPTH)+1`: occupancy.
- `overflow` out 1: sticky, set when an event is dropped.
- `clr_ovf` in 1: clears `overflow`.

## Operation
- Reset values:
  - `key_state` = 0, `ev_valid` = 0, `ev_data` = 0, `ev_count` = 0, `overflow` = 0.
  - FSM in IDLE, FIFO pointers 0, timeout counter 0.
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on `rx_valid`.
  - `E0`: IDLE→EXT, BRK→EXT_BRK, EXT→EXT, EXT_BRK→EXT_BRK.
  - `F0`: IDLE→BRK, EXT→EXT_BRK, BRK→BRK, EXT_BRK→EXT_BRK.
  - Any other byte is a terminal code. It is decoded using the current state, then the FSM returns to IDLE.
- Decode table:
  - Non-extended: `1D`→0, `1C`→1, `1B`→2, `23`→3, `29`→4, `5A`→9.
  - Extended: `75`→5, `6B`→6, `72`→7, `74`→8.
  - A code is valid only with a matching extended flag. Example: `75` without `E0` is ignored.
  - `E1`, `AA`, `FA`, `EE`, `FE` and all other codes: ignored, FSM → IDLE.
- Make (IDLE/EXT states): if `key_state[k]` = 0, set it and enqueue `{1,k}`. If already 1 (typematic), no event.
- Break (BRK/EXT_BRK states): if `key_state[k]` = 1, clear it and enqueue `{0,k}`. If already 0, no event.
- FIFO:
  - Write when an event is generated. Read on `ev_rd && ev_valid`.
  - Push with the FIFO full and no pop in the same cycle: event dropped, `overflow` ← 1. `key_state` still updates.
  - Push and pop in the same cycle, at any occupancy including full: both succeed, count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `overflow`: `clr_ovf` clears it. If `clr_ovf` and a new drop occur in the same cycle, set wins.
- `reset` asserted mid-sequence (e.g. after `E0`): FSM → IDLE, bitmap and FIFO cleared. The next terminal byte is treated as non-extended.

## Timing
- `rx_valid` at edge N → `key_state`, `ev_valid`, `ev_count` reflect the byte after edge N (one-cycle latency).
- `ev_data` is valid whenever `ev_valid` = 1. It is a registered head read with no extra latency after the push edge.
- After a pop at edge N, the next head appears after edge N.
- Back-to-back `rx_valid` on consecutive cycles is supported.

## Configuration
- `KEY_CTRL_TIMEOUT_EN` defined:
  - A counter runs while the FSM is not IDLE and clears on every `rx_valid`.
  - On reaching `TIMEOUT_CYCLES-1` with no new byte, the FSM → IDLE with no event, so a lost byte cannot corrupt the next key.
  - `rx_valid` in the timeout cycle takes priority: the byte is processed normally.
- Undefined: no counter logic is compiled in, and prefixes persist indefinitely until a terminal byte arrives.

## Test plan
- Bytes `1D`, then `F0 1D` → `key_state[0]` 1 then 0; FIFO holds `{1,0}` then `{0,0}`; `ev_count` reaches 2.
- `E0 75`, `E0 F0 75`, then bare `75` → events `{1,5}` and `{0,5}` only; the bare `75` produces nothing.
- `1C` sent three times (typematic) → a single `{1,1}` event; `key_state[1]` = 1.
- Five distinct makes with `FIFO_DEPTH` = 4 and no reads → `ev_count` = 4, `overflow` = 1, `key_state` shows all 5 keys. Then `clr_ovf` → `overflow` = 0.
- FIFO full, then push and `ev_rd` in the same cycle → `ev_count` stays 4, the oldest event leaves, the new event is at the tail.
- With `KEY_CTRL_TIMEOUT_EN`: `E0`, idle `TIMEOUT_CYCLES` cycles, then `75` → no event. The same sequence without the macro → `{1,5}`. Also `reset` asserted after `F0`, then `23` → `{1,3}`.

Source files
------------

// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if: byte-in / key-event-out bundle between the PS/2 receiver, the key controller and the game FSM
interface ps2_key_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                        rx_valid;
  logic [7:0]                  rx_data;
  logic [9:0]                  key_state;
  logic                        ev_valid;
  logic [4:0]                  ev_data;
  logic                        ev_rd;
  logic [$clog2(FIFO_DEPTH):0] ev_count;
  logic                        overflow;
  logic                        clr_ovf;
  modport master (
    output rx_valid, rx_data, ev_rd, clr_ovf,
    input  key_state, ev_valid, ev_data, ev_count, overflow
  );
  modport slave (
    input  rx_valid, rx_data, ev_rd, clr_ovf,
    output key_state, ev_valid, ev_data, ev_count, overflow
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: set-2 prefix tracker, key bitmap and event FIFO; KEY_CTRL_TIMEOUT_EN adds a prefix-abandon timeout
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1250000
) (
  input logic           clk,
  input logic           reset,
  ps2_key_ctrl_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t          state_q, state_d;
  logic [9:0]      key_state_q, key_state_d;
  logic [4:0]      mem_q [FIFO_DEPTH];
  logic [4:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            ext, brk, hit, push, pop, full, wr, drop, tmo_fire;
  logic [3:0]      k;
  logic [4:0]      ev_word;
`ifdef KEY_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // count idle cycles spent inside a prefix; any byte restarts the count
  always_comb begin
    tmo_fire = !bus.rx_valid && state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    tmo_d    = (bus.rx_valid || state_q == IDLE || tmo_fire) ? '0 : tmo_q + 1'b1;
  end
  // timeout counter register
  always_ff @(posedge clk) tmo_q <= reset ? '0 : tmo_d;
`else
  assign tmo_fire = 1'b0;
`endif
  // map the byte plus the extended flag onto a player key index
  always_comb begin
    ext = state_q == EXT || state_q == EXT_BRK;
    brk = state_q == BRK || state_q == EXT_BRK;
    hit = 1'b1;
    k   = 4'd0;
    case ({ext, bus.rx_data})
      9'h01D: k = 4'd0;
      9'h01C: k = 4'd1;
      9'h01B: k = 4'd2;
      9'h023: k = 4'd3;
      9'h029: k = 4'd4;
      9'h05A: k = 4'd9;
      9'h175: k = 4'd5;
      9'h16B: k = 4'd6;
      9'h172: k = 4'd7;
      9'h174: k = 4'd8;
      default: hit = 1'b0;
    endcase
  end
  // prefix FSM, bitmap update and event generation; repeats of the current level make no event
  always_comb begin
    state_d     = state_q;
    key_state_d = key_state_q;
    push        = 1'b0;
    ev_word     = 5'd0;
    if (bus.rx_valid) begin
      if (bus.rx_data == 8'hE0) state_d = brk ? EXT_BRK : EXT;
      else if (bus.rx_data == 8'hF0) state_d = ext ? EXT_BRK : BRK;
      else begin
        state_d = IDLE;
        if (hit && key_state_q[k] == brk) begin
          key_state_d[k] = !brk;
          push           = 1'b1;
          ev_word        = {!brk, k};
        end
      end
    end else if (tmo_fire) state_d = IDLE;
  end
  // event FIFO: a push into a full FIFO only lands if a pop frees the head slot that same cycle
  always_comb begin
    pop        = bus.ev_rd && count_q != '0;
    full       = count_q == CW'(FIFO_DEPTH);
    wr         = push && (!full || pop);
    drop       = push && full && !pop;
    wr_ptr_d   = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(wr) - CW'(pop);
    overflow_d = drop ? 1'b1 : bus.clr_ovf ? 1'b0 : overflow_q;
    mem_d      = mem_q;
    if (wr) mem_d[wr_ptr_q] = ev_word;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      key_state_q <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_state_q <= key_state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end
  assign bus.key_state = key_state_q;
  assign bus.ev_valid  = count_q != '0;
  assign bus.ev_data   = mem_q[rd_ptr_q];
  assign bus.ev_count  = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed vector table plus reset/timeout sequences for ps2_key_ctrl
module tb_ps2_key_ctrl;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  ps2_key_ctrl_if #(.FIFO_DEPTH(4)) bus ();
  ps2_key_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       rv;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic [9:0] ks;
    logic [2:0] cnt;
    logic [4:0] dat;
    logic       ovf;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(logic rv, logic [7:0] d, logic rd, logic clr,
                             logic [9:0] ks, logic [2:0] cnt, logic [4:0] dat, logic ovf);
    v = '{rv, d, rd, clr, ks, cnt, dat, ovf};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic rv, input logic [7:0] d, input logic rd, input logic clr);
    bus.rx_valid = rv;
    bus.rx_data  = d;
    bus.ev_rd    = rd;
    bus.clr_ovf  = clr;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.ev_rd    = 1'b0;
    bus.clr_ovf  = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 8'h00, 0, 0);
    reset = 1'b0;
  endtask
  task automatic check_ev(input string name, input logic [2:0] cnt, input logic [4:0] dat);
    check({name, "_cnt"}, 32'(bus.ev_count), 32'(cnt));
    check({name, "_valid"}, 32'(bus.ev_valid), 32'(cnt != 0));
    if (cnt != 0) check({name, "_data"}, 32'(bus.ev_data), 32'(dat));
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.ev_rd    = 1'b0;
    bus.clr_ovf  = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_key_state", 32'(bus.key_state), 0);
    check("rst_ev_valid", 32'(bus.ev_valid), 0);
    check("rst_ev_data", 32'(bus.ev_data), 0);
    check("rst_ev_count", 32'(bus.ev_count), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    reset = 1'b0;
    tv.push_back(v(1, 8'h1D, 0, 0, 10'h000 | 10'h001, 1, 5'h10, 0));
    tv.push_back(v(1, 8'hF0, 0, 0, 10'h001, 1, 5'h10, 0));
    tv.push_back(v(1, 8'h1D, 0, 0, 10'h000, 2, 5'h10, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h000, 1, 5'h00, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h000, 0, 5'h00, 0));
    tv.push_back(v(1, 8'hE0, 0, 0, 10'h000, 0, 5'h00, 0));
    tv.push_back(v(1, 8'h75, 0, 0, 10'h020, 1, 5'h15, 0));
    tv.push_back(v(1, 8'hE0, 0, 0, 10'h020, 1, 5'h15, 0));
    tv.push_back(v(1, 8'hF0, 0, 0, 10'h020, 1, 5'h15, 0));
    tv.push_back(v(1, 8'h75, 0, 0, 10'h000, 2, 5'h15, 0));
    tv.push_back(v(1, 8'h75, 0, 0, 10'h000, 2, 5'h15, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h000, 1, 5'h05, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h000, 0, 5'h00, 0));
    tv.push_back(v(1, 8'h1C, 0, 0, 10'h002, 1, 5'h11, 0));
    tv.push_back(v(1, 8'h1C, 0, 0, 10'h002, 1, 5'h11, 0));
    tv.push_back(v(1, 8'h1C, 0, 0, 10'h002, 1, 5'h11, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h002, 0, 5'h00, 0));
    tv.push_back(v(1, 8'h1D, 0, 0, 10'h003, 1, 5'h10, 0));
    tv.push_back(v(1, 8'h1B, 0, 0, 10'h007, 2, 5'h10, 0));
    tv.push_back(v(1, 8'h23, 0, 0, 10'h00F, 3, 5'h10, 0));
    tv.push_back(v(1, 8'h29, 0, 0, 10'h01F, 4, 5'h10, 0));
    tv.push_back(v(1, 8'h5A, 0, 0, 10'h21F, 4, 5'h10, 1));
    tv.push_back(v(0, 8'h00, 0, 1, 10'h21F, 4, 5'h10, 0));
    tv.push_back(v(1, 8'hE0, 0, 0, 10'h21F, 4, 5'h10, 0));
    tv.push_back(v(1, 8'h6B, 1, 0, 10'h25F, 4, 5'h12, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h25F, 3, 5'h13, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h25F, 2, 5'h14, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h25F, 1, 5'h16, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h25F, 0, 5'h00, 0));
    tv.push_back(v(0, 8'h00, 1, 0, 10'h25F, 0, 5'h00, 0));
    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].rv, tv[i].d, tv[i].rd, tv[i].clr);
      check($sformatf("v%0d_key_state", i), 32'(bus.key_state), 32'(tv[i].ks));
      check_ev($sformatf("v%0d", i), tv[i].cnt, tv[i].dat);
      check($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'(tv[i].ovf));
    end
    // reset after a break prefix: next terminal byte is a plain make
    do_reset();
    cyc(1, 8'hF0, 0, 0);
    reset = 1'b1;
    cyc(0, 8'h00, 0, 0);
    reset = 1'b0;
    check("midrst_key_state", 32'(bus.key_state), 0);
    check("midrst_ev_count", 32'(bus.ev_count), 0);
    cyc(1, 8'h23, 0, 0);
    check("midrst_key3", 32'(bus.key_state), 32'h008);
    check_ev("midrst_ev", 1, 5'h13);
    // fill, then a drop and a clear in the same cycle: set wins
    do_reset();
    cyc(1, 8'h1D, 0, 0);
    cyc(1, 8'h1C, 0, 0);
    cyc(1, 8'h1B, 0, 0);
    cyc(1, 8'h23, 0, 0);
    cyc(1, 8'h29, 0, 1);
    check("setwins_overflow", 32'(bus.overflow), 1);
    check_ev("setwins_ev", 4, 5'h10);
    // one cycle short of the timeout: the prefix is still honoured
    do_reset();
    cyc(1, 8'hE0, 0, 0);
    repeat (TMO - 1) cyc(0, 8'h00, 0, 0);
    cyc(1, 8'h75, 0, 0);
    check("tmo_edge_key_state", 32'(bus.key_state), 32'h020);
    check_ev("tmo_edge_ev", 1, 5'h15);
    // full timeout elapses between E0 and 75
    do_reset();
    cyc(1, 8'hE0, 0, 0);
    repeat (TMO) cyc(0, 8'h00, 0, 0);
    cyc(1, 8'h75, 0, 0);
`ifdef KEY_CTRL_TIMEOUT_EN
    check("tmo_key_state", 32'(bus.key_state), 0);
    check_ev("tmo_ev", 0, 5'h00);
`else
    check("tmo_key_state", 32'(bus.key_state), 32'h020);
    check_ev("tmo_ev", 1, 5'h15);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
